adder_accum: RTL and testbench
==============================

Name: adder_accum

Overview:
- Downstream consumer of the 4-bit ripple adder (dataA/dataB -> sum/carry).
- Takes each adder result as a 5-bit value {carry,sum} over a valid/ready handshake and accumulates a programmable-length batch into a wider register.
- Presents the final total, sample count and a sticky overflow flag on an output handshake.
- Feeds the result readout / display stage.

Parameters:
- ACC_W, 8: accumulator width in bits; must be >= 5.
- CNT_W, 4: width of batch length and sample counter; maximum batch is 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a batch. Honoured only in IDLE.
- batch_len  in  CNT_W  number of samples in the batch; sampled on an accepted start.
- in_valid  in  1  the sum/carry pair is valid.
- in_ready  out  1  the block accepts a sample this cycle.
- sum  in  4  adder sum output.
- carry  in  1  adder carry output.
- out_valid  out  1  the result is available.
- out_ready  in  1  the downstream stage takes the result.
- out_acc  out  ACC_W  accumulated total, modulo 2^ACC_W.
- out_count  out  CNT_W  number of samples accepted in the batch.
- out_ovf  out  1  sticky flag: the total exceeded 2^ACC_W-1 at least once.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: synchronous, active-high, has priority over everything. Clears the state to IDLE.
- Values forced by reset: in_ready=0, out_valid=0, out_acc=0, out_count=0, out_ovf=0, busy=0. The latched batch length is also cleared to 0.
- Reset asserted mid-batch discards the partial result with no output. The block is in IDLE on the cycle after rst deasserts.
- States: IDLE, ACCUM, DONE. Transitions:
  - IDLE: in_ready=0, out_valid=0.
  - IDLE, start=1: latch batch_len; clear acc, count and ovf.
  - If batch_len==0, go straight to DONE with acc=0, count=0.
  - Otherwise go to ACCUM.
  - ACCUM: in_ready=1 (registered, asserted the cycle after start is accepted).
  - Sample transfer: in_valid & in_ready. Compute acc_next = acc + zero-extend({carry,sum}) at ACC_W+1 bits.
  - On a transfer: acc <= acc_next[ACC_W-1:0]; ovf <= ovf | acc_next[ACC_W]; count <= count+1.
  - On the transfer where count+1 == latched length, go to DONE. in_ready drops the following cycle.
  - in_valid=0 in ACCUM is a stall: no change, no timeout.
  - DONE: out_valid=1. out_acc, out_count and out_ovf are stable and must not change while out_valid=1 and out_ready=0.
  - DONE, out_ready=1: go to IDLE next cycle; out_valid drops.
  - The out_acc, out_count and out_ovf values are held in IDLE until the next accepted start.
- start outside IDLE is ignored: no effect on state, acc or the latched length. start has no effect in the same cycle as rst.
- Latency: a result is valid 1 cycle after the final sample transfer. With a zero-length batch, it is valid 1 cycle after start.
- Throughput: one sample per cycle in ACCUM. At least 2 idle cycles between batches: DONE->IDLE, then start.
- in_valid and sum/carry are don't-care outside ACCUM. No sample is consumed outside ACCUM.
- All outputs are registered; there is no combinational path from any input to any output.

Test Plan:
- Reset, then batch_len=4. Feed the adder vectors 0+1, 1+1, 3+2, 15+1, i.e. {c,s}=0x01, 0x02, 0x05, 0x10, back-to-back -> out_valid one cycle after the 4th transfer; out_acc=0x18 (24), out_count=4, out_ovf=0.
- batch_len=15, all samples {c,s}=0x1F (31) -> out_ovf rises on the 9th transfer (279) and stays 1; final out_acc=465 mod 256=0xD1 (209), out_count=15.
- batch_len=3, in_valid toggled 1,0,0,1,0,1 with sums 2, 3, 4 -> only the valid cycles count; out_acc=9, out_count=3, in_ready held high throughout the gaps.
- Backpressure: the result is ready with out_ready=0 for 5 cycles -> out_valid stays 1 and the outputs are stable; a start pulse during DONE is ignored. Then out_ready=1 -> IDLE, busy=0.
- batch_len=0 with start -> DONE next cycle: out_acc=0, out_count=0, out_ovf=0; in_ready never asserted.
- rst pulsed after 2 of 4 samples -> all outputs cleared; a new start with batch_len=1 and sample 0x07 -> out_acc=7, out_count=1.

Source files
------------

// File: rtl/adder_accum.sv
// adder_accum: accumulates a batch of 5-bit adder results {carry,sum}.
// Sample input and result output both use valid/ready handshakes.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start, batch_len   begin a batch of batch_len samples (IDLE only)
//   in_valid/in_ready  sample handshake carrying sum[3:0] and carry
//   out_valid/out_ready result handshake
//   out_acc            total modulo 2^ACC_W
//   out_count          samples accepted in the batch
//   out_ovf            sticky: total passed 2^ACC_W-1 at least once
//   busy               high whenever not IDLE
module adder_accum #(
    parameter int ACC_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] batch_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sum,
    input  logic             carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;

    logic             xfer;
    logic             go;
    logic [ACC_W:0]   acc_next;
    logic [CNT_W-1:0] cnt_inc;

    // Outputs are plain decodes of flops; no input reaches an output
    // without passing through a register.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_acc   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

    assign go       = start & (state == IDLE);
    assign xfer     = in_valid & (state == ACCUM);
    // One extra bit so the carry out of the accumulator is visible.
    assign acc_next = {1'b0, acc_q} + {{(ACC_W-4){1'b0}}, carry, sum};
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (batch_len == '0) state_nx = DONE;
                    else                 state_nx = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid && (cnt_inc == len_q)) state_nx = DONE;
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= '0;
            cnt_q <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (go) begin
            len_q <= batch_len;
            cnt_q <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (xfer) begin
            acc_q <= acc_next[ACC_W-1:0];
            ovf_q <= ovf_q | acc_next[ACC_W];
            cnt_q <= cnt_inc;
        end
    end

endmodule

// File: tb/tb_adder_accum.sv
// tb_adder_accum: vector table, hand sequences and random batches
// checked against a plain-arithmetic model of the batch total.
module tb_adder_accum;

    localparam int ACC_W = 8;
    localparam int CNT_W = 4;
    localparam int MODV  = 2 ** ACC_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] batch_len;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       sum;
    logic             carry;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    logic             busy;

    int ncmp  = 0;
    int nfail = 0;

    logic [4:0] smp [15];

    typedef struct {
        int         len;
        logic [4:0] s [15];
        int         gm;
        int         hold;
        int         exp_acc;
        int         exp_cnt;
        int         exp_ovf;
    } vec_t;

    vec_t vt [5];

    adder_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .batch_len (batch_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .carry     (carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // gm: 0 back-to-back, 1 random gaps, 2 fixed pattern 1,0,0,1,0,1
    task automatic run_batch(input int len, input int gm, input int hold,
                             input string tag);
        int total;
        int i;
        int c;
        bit v;
        logic [5:0] pat;
        logic [ACC_W-1:0] h_acc;
        logic [CNT_W-1:0] h_cnt;
        logic             h_ovf;
        total = 0;
        i = 0;
        c = 0;
        pat = 6'b101001;
        start = 1'b1;
        batch_len = len[CNT_W-1:0];
        tick();
        start = 1'b0;
        check({tag, " busy after start"}, int'(busy), 1);
        if (len == 0) begin
            check({tag, " zero-len valid"}, int'(out_valid), 1);
            check({tag, " zero-len ready"}, int'(in_ready), 0);
        end else begin
            check({tag, " valid in accum"}, int'(out_valid), 0);
            while (i < len && c < 200) begin
                if (gm == 0)      v = 1'b1;
                else if (gm == 1) v = ($urandom_range(0, 2) != 0);
                else              v = (c < 6) ? pat[c] : 1'b1;
                if (!in_ready) check({tag, " in_ready"}, int'(in_ready), 1);
                in_valid = v;
                {carry, sum} = v ? smp[i] : 5'($urandom);
                tick();
                c++;
                in_valid = 1'b0;
                if (v) begin
                    total += int'(smp[i]);
                    i++;
                    check({tag, " running ovf"}, int'(out_ovf),
                          int'(total > MODV - 1));
                end
                if (i < len && out_valid)
                    check({tag, " early valid"}, int'(out_valid), 0);
            end
            if (i < len) check({tag, " timeout"}, i, len);
            check({tag, " latency valid"}, int'(out_valid), 1);
            check({tag, " in_ready drop"}, int'(in_ready), 0);
        end
        check({tag, " acc"}, int'(out_acc), total % MODV);
        check({tag, " count"}, int'(out_count), len);
        check({tag, " ovf"}, int'(out_ovf), int'(total > MODV - 1));
        h_acc = out_acc;
        h_cnt = out_count;
        h_ovf = out_ovf;
        out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            if (k == 1) begin
                start = 1'b1;
                batch_len = 4'd7;
            end
            tick();
            start = 1'b0;
            check({tag, " hold valid"}, int'(out_valid), 1);
            check({tag, " hold stable"},
                  int'({out_acc, out_count, out_ovf}),
                  int'({h_acc, h_cnt, h_ovf}));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " valid drop"}, int'(out_valid), 0);
        check({tag, " idle busy"}, int'(busy), 0);
        check({tag, " idle held acc"}, int'(out_acc), total % MODV);
        tick();
        check({tag, " still idle"}, int'(busy), 0);
    endtask

    initial begin
        int t;
        int len;
        rst = 1'b1;
        start = 1'b0;
        batch_len = '0;
        in_valid = 1'b0;
        sum = '0;
        carry = 1'b0;
        out_ready = 1'b0;

        vt[0].len = 4; vt[0].gm = 0; vt[0].hold = 5;
        vt[0].s[0] = 5'h01; vt[0].s[1] = 5'h02;
        vt[0].s[2] = 5'h05; vt[0].s[3] = 5'h10;
        vt[0].exp_acc = 24; vt[0].exp_cnt = 4; vt[0].exp_ovf = 0;
        vt[1].len = 15; vt[1].gm = 0; vt[1].hold = 0;
        for (int k = 0; k < 15; k++) vt[1].s[k] = 5'h1F;
        vt[1].exp_acc = 209; vt[1].exp_cnt = 15; vt[1].exp_ovf = 1;
        vt[2].len = 3; vt[2].gm = 2; vt[2].hold = 0;
        vt[2].s[0] = 5'd2; vt[2].s[1] = 5'd3; vt[2].s[2] = 5'd4;
        vt[2].exp_acc = 9; vt[2].exp_cnt = 3; vt[2].exp_ovf = 0;
        vt[3].len = 0; vt[3].gm = 0; vt[3].hold = 2;
        vt[3].exp_acc = 0; vt[3].exp_cnt = 0; vt[3].exp_ovf = 0;
        vt[4].len = 2; vt[4].gm = 1; vt[4].hold = 1;
        vt[4].s[0] = 5'h1F; vt[4].s[1] = 5'h1F;
        vt[4].exp_acc = 62; vt[4].exp_cnt = 2; vt[4].exp_ovf = 0;

        tick();
        tick();
        check("reset in_ready", int'(in_ready), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_acc", int'(out_acc), 0);
        check("reset out_count", int'(out_count), 0);
        check("reset out_ovf", int'(out_ovf), 0);
        check("reset busy", int'(busy), 0);
        rst = 1'b0;
        tick();

        for (int n = 0; n < 5; n++) begin
            for (int k = 0; k < 15; k++) smp[k] = vt[n].s[k];
            run_batch(vt[n].len, vt[n].gm, vt[n].hold, $sformatf("vec%0d", n));
            check($sformatf("vec%0d table acc", n), int'(out_acc), vt[n].exp_acc);
            check($sformatf("vec%0d table cnt", n), int'(out_count), vt[n].exp_cnt);
            check($sformatf("vec%0d table ovf", n), int'(out_ovf), vt[n].exp_ovf);
        end

        // Reset in the middle of a batch, with start also high.
        start = 1'b1;
        batch_len = 4'd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            {carry, sum} = 5'h13;
            tick();
        end
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        check("midrst acc", int'(out_acc), 0);
        check("midrst count", int'(out_count), 0);
        check("midrst ovf", int'(out_ovf), 0);
        check("midrst valid", int'(out_valid), 0);
        check("midrst ready", int'(in_ready), 0);
        check("midrst busy", int'(busy), 0);
        tick();
        check("midrst idle", int'(busy), 0);
        smp[0] = 5'h07;
        run_batch(1, 0, 0, "post-rst");
        check("post-rst acc", int'(out_acc), 7);
        check("post-rst count", int'(out_count), 1);

        for (int r = 0; r < 20; r++) begin
            len = $urandom_range(0, 15);
            for (int k = 0; k < 15; k++) smp[k] = 5'($urandom);
            t = $urandom_range(0, 3);
            run_batch(len, 1, t, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
